// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receive path.
//   CHAR_XON / CHAR_XOFF : in-band flow-control characters
//   rx_state_e           : receiver state encoding
//   calc_div             : sys_clk cycles per oversample tick
//   maj3 / xor64         : voting and parity helpers
package uart_pkg;

  localparam logic [7:0] CHAR_XON  = 8'd17;
  localparam logic [7:0] CHAR_XOFF = 8'd19;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Truncated clk/(baud*os), never below one cycle per tick.
  function automatic int unsigned calc_div(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned os);
    longint unsigned d;
    if ((baud * os) == 64'd0) begin
      d = 64'd1;
    end else begin
      d = clk_hz / (baud * os);
    end
    if (d < 64'd1) begin
      d = 64'd1;
    end else begin
      d = d;
    end
    return 32'(d);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic xor64(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick divider.
//   sys_clk : system clock
//   reset_n : synchronous active-low reset
//   restart : realigns the divider to the current cycle (start-bit edge)
//   os_tick : one-cycle pulse every DIV cycles
module uart_os_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic restart,
  output logic os_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick decode; with DIV=1 every cycle is a tick.
  assign os_tick = (cnt_q == LAST);

  // Divider next value: restart wins over the free-running wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider register.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver: 16x oversampling, 3-sample majority vote, optional parity,
// stop-bit check, XON/XOFF consumption and a one-entry output holding register.
//   sys_clk, reset_n      : clock, synchronous active-low reset
//   rx                    : asynchronous serial line, idle high
//   dout/so/ro            : received frame, send (valid), downstream ready
//   xon_detect/xoff_detect: flow-control character pulses
//   parity_error, frame_error, overrun : one-cycle error pulses
//   busy                  : a frame is in progress
module uart_rx_oversample #(
  parameter int unsigned FRAME_WIDTH       = 8,
  parameter int unsigned BAUD_RATE         = 12800,
  parameter int unsigned SYS_CLK_FREQ      = 2_000_000_000,
  parameter int unsigned OVERSAMPLE        = 16,
  parameter bit          PARITY_EN         = 1'b1,
  parameter bit          PARITY_ODD        = 1'b0,
  parameter bit          FILTER_FLOW_CHARS = 1'b1
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   rx,
  output logic [0:FRAME_WIDTH-1] dout,
  output logic                   so,
  input  logic                   ro,
  output logic                   xon_detect,
  output logic                   xoff_detect,
  output logic                   parity_error,
  output logic                   frame_error,
  output logic                   overrun,
  output logic                   busy
);

  import uart_pkg::*;

  localparam int unsigned DIV = calc_div(64'(SYS_CLK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLE));
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_MAJ  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_WIDTH - 1);
  localparam logic [FRAME_WIDTH-1:0] XON_W  = FRAME_WIDTH'(CHAR_XON);
  localparam logic [FRAME_WIDTH-1:0] XOFF_W = FRAME_WIDTH'(CHAR_XOFF);

  rx_state_e state_q, state_d;
  logic rx_meta_q, rx_sync_q;
  logic line_armed_q, line_armed_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] samp_q, samp_d;
  logic [FRAME_WIDTH-1:0] shift_q, shift_d;
  logic par_err_q, par_err_d;
  // Holding register kept LSB-at-0; the ascending port maps it to dout[FRAME_WIDTH-1].
  logic [FRAME_WIDTH-1:0] dout_q, dout_d;
  logic so_q, so_d;
  logic xon_q, xon_d, xoff_q, xoff_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic os_tick, start_det, maj_pt, bit_end, bit_maj;

  uart_os_tick_gen #(.DIV(DIV)) u_tick (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .restart (start_det),
    .os_tick (os_tick)
  );

  assign start_det = (state_q == IDLE) && line_armed_q && !rx_sync_q;
  assign maj_pt    = os_tick && (tick_cnt_q == TICK_MAJ);
  assign bit_end   = os_tick && (tick_cnt_q == TICK_LAST);
  // Third vote is the live synchronised sample at the majority tick.
  assign bit_maj   = maj3(samp_q[0], samp_q[1], rx_sync_q);

  assign dout         = dout_q;
  assign so           = so_q;
  assign xon_detect   = xon_q;
  assign xoff_detect  = xoff_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != IDLE);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_det) state_d = START; else state_d = IDLE;
      START:   if (maj_pt && bit_maj) state_d = IDLE;
               else if (bit_end) state_d = DATA;
               else state_d = START;
      DATA:    if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = PARITY_EN ? PARITY : STOP;
               else state_d = DATA;
      PARITY:  if (bit_end) state_d = STOP; else state_d = PARITY;
      // Finish at the stop majority point to leave half a bit of slack.
      STOP:    if (maj_pt) state_d = IDLE; else state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Bit timing, sampling, shift register, parity and line arming.
  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    samp_d       = samp_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    line_armed_d = line_armed_q;

    if (state_q == IDLE) begin
      tick_cnt_d = '0;
    end else if (os_tick) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    if (os_tick && (tick_cnt_q == TICK_S0)) begin
      samp_d[0] = rx_sync_q;
    end else if (os_tick && (tick_cnt_q == TICK_S1)) begin
      samp_d[1] = rx_sync_q;
    end else begin
      samp_d = samp_q;
    end

    if (state_q != DATA) begin
      bit_cnt_d = '0;
    end else if (bit_end) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    // LSB first: each new bit enters at the top and walks down to bit 0.
    if ((state_q == DATA) && maj_pt) begin
      shift_d = {bit_maj, shift_q[FRAME_WIDTH-1:1]};
    end else begin
      shift_d = shift_q;
    end

    if (state_q == IDLE) begin
      par_err_d = 1'b0;
    end else if ((state_q == PARITY) && maj_pt) begin
      par_err_d = bit_maj ^ xor64(64'(shift_q)) ^ PARITY_ODD;
    end else begin
      par_err_d = par_err_q;
    end

    // A low stop bit disarms so a held break cannot retrigger.
    if ((state_q == STOP) && maj_pt && !bit_maj) begin
      line_armed_d = 1'b0;
    end else if ((state_q == IDLE) && rx_sync_q) begin
      line_armed_d = 1'b1;
    end else begin
      line_armed_d = line_armed_q;
    end
  end

  // Frame completion priority and holding-register handshake.
  always_comb begin
    so_d   = so_q && !ro;
    dout_d = dout_q;
    xon_d  = 1'b0;
    xoff_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    ovr_d  = 1'b0;
    if ((state_q == STOP) && maj_pt) begin
      if (!bit_maj) begin
        ferr_d = 1'b1;
      end else if (PARITY_EN && par_err_q) begin
        perr_d = 1'b1;
      end else if (FILTER_FLOW_CHARS && (shift_q == XON_W)) begin
        xon_d = 1'b1;
      end else if (FILTER_FLOW_CHARS && (shift_q == XOFF_W)) begin
        xoff_d = 1'b1;
      end else if (so_q && !ro) begin
        ovr_d = 1'b1;
      end else begin
        dout_d = shift_q;
        so_d   = 1'b1;
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // Synchroniser, datapath and output registers.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      line_armed_q <= 1'b0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      dout_q       <= '0;
      so_q         <= 1'b0;
      xon_q        <= 1'b0;
      xoff_q       <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      line_armed_q <= line_armed_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      dout_q       <= dout_d;
      so_q         <= so_d;
      xon_q        <= xon_d;
      xoff_q       <= xoff_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

endmodule
